// File: rtl/if_id_queue.sv
// ============================================================================
// if_id_queue
// ----------------------------------------------------------------------------
// Parametrised IF/ID buffer for the LC-3b pipeline. A circular FIFO of
// DEPTH {instr, pc} pairs sits between fetch and decode. The head entry is
// sliced combinationally into the LC-3b register/immediate fields. Flush
// discards every buffered entry, and count reports the current occupancy.
//
// Optional feature (macro IFID_BYPASS_EN):
//   While the queue is empty, a valid fetch is presented to decode in the
//   same cycle. If decode takes it, the entry is never written. Without the
//   macro there is no combinational path from instr/pc_in to the outputs.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     fetch-side handshake (in_ready == ~full)
//   instr, pc_in          fetched instruction and its PC
//   flush                 discard all entries (priority over enq/deq)
//   out_valid/out_ready   decode-side handshake for the head entry
//   pc_out                PC of the head entry
//   opcode .. jsr_sel     decoded fields of the head instruction
//                         (all driven to 0 while out_valid is low)
//   count                 number of occupied entries
// ============================================================================
module if_id_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic [3:0]       opcode,
    output logic [2:0]       dest,
    output logic [2:0]       src1,
    output logic [2:0]       src2,
    output logic [3:0]       imm4,
    output logic [4:0]       imm5,
    output logic [5:0]       offset6,
    output logic [8:0]       offset9,
    output logic [10:0]      offset11,
    output logic [7:0]       trapvect8,
    output logic             imm5_sel,
    output logic             a,
    output logic             d,
    output logic             jsr_sel,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Storage is deliberately not reset.
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             full;
    logic             empty;
    logic             bypass;
    logic             bypass_take;
    logic             enq;
    logic             deq;
    logic [WIDTH-1:0] head_instr;
    logic [WIDTH-1:0] head_pc;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = ~full;
    assign count    = count_q;

`ifdef IFID_BYPASS_EN
    // Reset gates the bypass so outputs stay at 0 while reset is asserted.
    assign bypass      = empty & in_valid & ~flush & ~reset;
    assign bypass_take = bypass & out_ready;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign out_valid = ~empty | bypass;

    // A bypassed entry consumed in the same cycle is never written.
    assign enq = in_valid & in_ready & ~flush & ~bypass_take;
    // Only stored entries advance rd_ptr; the bypass path leaves it alone.
    assign deq = ~empty & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + CNT_W'(1);
            else if (deq && !enq) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr_q] <= instr;
            pc_mem[wr_ptr_q]    <= pc_in;
        end
    end

    always_comb begin
        head_instr = '0;
        head_pc    = '0;
        if (!empty) begin
            head_instr = instr_mem[rd_ptr_q];
            head_pc    = pc_mem[rd_ptr_q];
        end else if (bypass) begin
            head_instr = instr;
            head_pc    = pc_in;
        end
    end

    assign pc_out    = head_pc;
    assign opcode    = head_instr[15:12];
    assign dest      = head_instr[11:9];
    assign src1      = head_instr[8:6];
    assign src2      = head_instr[2:0];
    assign imm4      = head_instr[3:0];
    assign imm5      = head_instr[4:0];
    assign offset6   = head_instr[5:0];
    assign offset9   = head_instr[8:0];
    assign offset11  = head_instr[10:0];
    assign trapvect8 = head_instr[7:0];
    assign imm5_sel  = head_instr[5];
    assign a         = head_instr[5];
    assign d         = head_instr[4];
    assign jsr_sel   = head_instr[11];

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pc_out;
    logic [3:0]       opcode;
    logic [2:0]       dest, src1, src2;
    logic [3:0]       imm4;
    logic [4:0]       imm5;
    logic [5:0]       offset6;
    logic [8:0]       offset9;
    logic [10:0]      offset11;
    logic [7:0]       trapvect8;
    logic             imm5_sel, a, d, jsr_sel;
    logic [CNT_W-1:0] count;

    if_id_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .imm4(imm4), .imm5(imm5), .offset6(offset6), .offset9(offset9),
        .offset11(offset11), .trapvect8(trapvect8),
        .imm5_sel(imm5_sel), .a(a), .d(d), .jsr_sel(jsr_sel),
        .count(count)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_TRAP = 4'hF;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Scoreboard of {instr, pc} in expected output order.
    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_count"},     32'(count), 32'd0);
        check({tag, "_fields"},
              32'(|{pc_out, opcode, dest, src1, src2, imm4, imm5, offset6, offset9,
                    offset11, trapvect8, imm5_sel, a, d, jsr_sel}), 32'd0);
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard,
    // update the scoreboard, then advance past the edge.
    task automatic step(input logic v, input logic [15:0] i, input logic [15:0] p,
                        input logic rdy, input logic fl);
        logic        has_head;
        logic        was_empty;
        logic        acc;
        logic [15:0] ei, ep;
        in_valid  = v;
        instr     = i;
        pc_in     = p;
        out_ready = rdy;
        flush     = fl;
        #1;
        has_head = 1'b0;
        ei = '0;
        ep = '0;
        was_empty = (sb.size() == 0);
        if (!was_empty) begin
            has_head = 1'b1;
            {ei, ep} = sb[0];
        end
`ifdef IFID_BYPASS_EN
        else if (v && !fl) begin
            has_head = 1'b1;
            ei = i;
            ep = p;
        end
`endif
        check("count",     32'(count), 32'(sb.size()));
        check("in_ready",  32'(in_ready), 32'(sb.size() != DEPTH));
        check("out_valid", 32'(out_valid), 32'(has_head));
        if (has_head) begin
            check("pc_out",    32'(pc_out), 32'(ep));
            check("opcode",    32'(opcode), 32'(ei[15:12]));
            check("dest",      32'(dest), 32'(ei[11:9]));
            check("src1",      32'(src1), 32'(ei[8:6]));
            check("src2",      32'(src2), 32'(ei[2:0]));
            check("imm4",      32'(imm4), 32'(ei[3:0]));
            check("imm5",      32'(imm5), 32'(ei[4:0]));
            check("offset6",   32'(offset6), 32'(ei[5:0]));
            check("offset9",   32'(offset9), 32'(ei[8:0]));
            check("offset11",  32'(offset11), 32'(ei[10:0]));
            check("trapvect8", 32'(trapvect8), 32'(ei[7:0]));
            check("bits",      32'({imm5_sel, a, d, jsr_sel}),
                               32'({ei[5], ei[5], ei[4], ei[11]}));
        end else begin
            check("idle_fields",
                  32'(|{pc_out, opcode, dest, src1, src2, imm4, imm5, offset6, offset9,
                        offset11, trapvect8, imm5_sel, a, d, jsr_sel}), 32'd0);
        end
        if (fl) begin
            sb.delete();
        end else begin
            acc = v && (sb.size() < DEPTH);
            if (!was_empty && rdy) void'(sb.pop_front());
`ifdef IFID_BYPASS_EN
            if (was_empty && v && rdy) acc = 1'b0;
`endif
            if (acc) sb.push_back({i, p});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; instr = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b0;
        #2;
        check_idle("reset_hi");
        @(posedge clk); #1;
        check_idle("reset_hi_edge");
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check_idle("post_reset");
        step(0, 16'h0000, 16'h0000, 0, 0);

        // ADD R1,R2,R3 passes straight through.
        step(1, 16'h1283, 16'h0040, 1, 0);
        check("add_opcode",   32'(opcode), 32'(OP_ADD));
        check("add_dest",     32'(dest), 32'd1);
        check("add_src1",     32'(src1), 32'd2);
        check("add_src2",     32'(src2), 32'd3);
        check("add_imm5_sel", 32'(imm5_sel), 32'd0);
        check("add_pc",       32'(pc_out), 32'h0040);
        step(0, 16'h0000, 16'h0000, 1, 0);
        step(0, 16'h0000, 16'h0000, 1, 0);

        // Fill, reject a third beat, then drain in order.
        step(1, 16'h5260, 16'h0100, 0, 0);
        step(1, 16'hF025, 16'h0102, 0, 0);
        check("full_count",    32'(count), 32'd2);
        check("full_in_ready", 32'(in_ready), 32'd0);
        step(1, 16'h0E05, 16'h0104, 0, 0);
        check("and_opcode",   32'(opcode), 32'(OP_AND));
        check("and_imm5_sel", 32'(imm5_sel), 32'd1);
        check("and_imm5",     32'(imm5), 32'd0);
        step(1, 16'h0E05, 16'h0104, 1, 0);
        check("trap_opcode", 32'(opcode), 32'(OP_TRAP));
        check("trap_vect",   32'(trapvect8), 32'h25);
        step(1, 16'h0E05, 16'h0104, 1, 0);
        check("br_opcode",  32'(opcode), 32'(OP_BR));
        check("br_offset9", 32'(offset9), 32'h005);
        step(0, 16'h0000, 16'h0000, 1, 0);

        // Flush with a JMP presented: everything dropped.
        step(1, 16'h3001, 16'h0200, 0, 0);
        step(1, 16'h3002, 16'h0202, 0, 0);
        step(1, 16'hC1C0, 16'h0204, 0, 1);
        check_idle("post_flush");
        step(0, 16'h0000, 16'h0000, 1, 0);

        // Asynchronous reset in the middle of a cycle.
        step(1, 16'h2345, 16'h0300, 0, 0);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1 check_idle("async_reset");
        sb.delete();
        #1 reset = 1'b0;
        step(0, 16'h0000, 16'h0000, 0, 0);
        step(1, 16'h6789, 16'h0302, 0, 0);
        check("after_reset_pc", 32'(pc_out), 32'h0302);
        step(0, 16'h0000, 16'h0000, 1, 0);
        step(0, 16'h0000, 16'h0000, 1, 0);

`ifdef IFID_BYPASS_EN
        // Same-cycle bypass of JSR into an empty queue.
        in_valid = 1'b1; instr = 16'h4802; pc_in = 16'h0400; out_ready = 1'b1; flush = 1'b0;
        #1;
        check("byp_valid",    32'(out_valid), 32'd1);
        check("byp_jsr_sel",  32'(jsr_sel), 32'd1);
        check("byp_offset11", 32'(offset11), 32'h002);
        step(1, 16'h4802, 16'h0400, 1, 0);
        check("byp_count", 32'(count), 32'd0);
`endif

        // Random traffic against the scoreboard.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        for (int k = 0; k < 4; k++) step(0, 16'h0000, 16'h0000, 1, 0);
        check("drain_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
